// File: rtl/i2c_slave_receiver_if.sv
// I2C write-receiver bus interface: bus pins plus the received-byte outputs.
// The master modport is the bus/consumer side, and the slave modport is the receiver block.
`timescale 1ns/1ps

interface i2c_slave_receiver_if;
    logic       scl_in;    // bus SCL level (asynchronous to clk)
    logic       sda_in;    // bus SDA level (asynchronous to clk)
    logic       sda_oe;    // 1 = receiver pulls SDA low
    logic [7:0] rx_data;   // last received data byte
    logic       rx_valid;  // one-clk pulse when rx_data updates
    logic       busy;      // receiver is addressed

    modport master (
        output scl_in,
        output sda_in,
        input  sda_oe,
        input  rx_data,
        input  rx_valid,
        input  busy
    );

    modport slave (
        input  scl_in,
        input  sda_in,
        output sda_oe,
        output rx_data,
        output rx_valid,
        output busy
    );
endinterface

// File: rtl/i2c_slave_receiver.sv
// I2C target write-receiver. It oversamples SCL and SDA in the clk domain and detects START and STOP.
// It matches a 7-bit address with R/W=0 and ACKs it. It then shifts in data bytes MSB-first, ACKs
// each byte, and pulses rx_valid for one clk per byte. SDA is only ever pulled low, and SCL is never driven.
// Optional build macro I2C_SLV_GLITCH_FILTER_EN adds a 3-sample majority filter on the synchronized
// SCL and SDA. The filter adds 2 clk of latency, and the minimum SCL phase then becomes 6 clk.
`timescale 1ns/1ps

module i2c_slave_receiver #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    i2c_slave_receiver_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        WAIT_STOP
    } state_t;

    // ---------------------------------------------------------------- input path
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;

    // Synchronize the asynchronous bus levels into the clk domain.
    // NOTE: sync flops reset to 1 (idle bus level) so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    logic scl_cur;
    logic sda_cur;

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;
    logic       scl_filt;
    logic       sda_filt;

    // Majority of three consecutive samples; a pulse lasting one clk never wins the vote.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_s};
            sda_hist <= {sda_hist[0], sda_s};
            scl_filt <= (scl_s & scl_hist[0]) | (scl_s & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
            sda_filt <= (sda_s & sda_hist[0]) | (sda_s & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
        end
    end

    assign scl_cur = scl_filt;
    assign sda_cur = sda_filt;
`else
    assign scl_cur = scl_s;
    assign sda_cur = sda_s;
`endif

    logic scl_prev;
    logic sda_prev;

    // One history flop per line for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_cur;
            sda_prev <= sda_cur;
        end
    end

    logic scl_r;
    logic scl_f;
    logic sda_r;
    logic sda_f;
    logic start_det;
    logic stop_det;

    logic       sda_oe_r;
    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] shift_next;
    logic       byte_done;

    assign scl_r = scl_cur & ~scl_prev;
    assign scl_f = ~scl_cur & scl_prev;
    assign sda_r = sda_cur & ~sda_prev;
    assign sda_f = ~sda_cur & sda_prev;

    // SDA edges only count as START/STOP while SCL is high and we are not driving SDA ourselves.
    assign start_det = sda_f & scl_cur & scl_prev & ~sda_oe_r;
    assign stop_det  = sda_r & scl_cur & scl_prev & ~sda_oe_r;

    assign shift_next = {shreg, sda_cur};
    assign byte_done  = scl_r && (bit_cnt == 3'd7);

    // ---------------------------------------------------------------- protocol FSM
    logic       ack_seen;   // 9th SCL rise seen while holding ACK
    logic       busy_r;
    logic [7:0] rx_data_r;
    logic       rx_valid_r;

    // Bus FSM: START/STOP first, then per-state bit processing; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 7'd0;
            ack_seen   <= 1'b0;
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else begin
            // NOTE: default-low here makes rx_valid a single-cycle pulse without extra clear logic.
            rx_valid_r <= 1'b0;
            if (start_det) begin
                state    <= ADDR;
                bit_cnt  <= 3'd0;
                shreg    <= 7'd0;
                ack_seen <= 1'b0;
                sda_oe_r <= 1'b0;
                busy_r   <= 1'b0;
            end else if (stop_det) begin
                state    <= IDLE;
                bit_cnt  <= 3'd0;
                ack_seen <= 1'b0;
                sda_oe_r <= 1'b0;
                busy_r   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sda_oe_r <= 1'b0;
                    end
                    ADDR: begin
                        if (scl_r) begin
                            shreg <= shift_next[6:0];
                            if (byte_done) begin
                                bit_cnt <= 3'd0;
                                if (shift_next == {SLAVE_ADDR, 1'b0}) state <= ADDR_ACK;
                                else                                  state <= WAIT_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        // Pull low after the 8th bit's SCL fall, hold through the 9th rise, release on its fall.
                        if (scl_f) begin
                            if (ack_seen) begin
                                sda_oe_r <= 1'b0;
                                ack_seen <= 1'b0;
                                bit_cnt  <= 3'd0;
                                state    <= DATA;
                            end else if (!sda_oe_r) begin
                                sda_oe_r <= 1'b1;
                                busy_r   <= 1'b1;
                            end
                        end else if (scl_r && sda_oe_r) begin
                            ack_seen <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (scl_r) begin
                            shreg <= shift_next[6:0];
                            if (byte_done) begin
                                bit_cnt    <= 3'd0;
                                rx_data_r  <= shift_next;
                                rx_valid_r <= 1'b1;
                                state      <= DATA_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    WAIT_STOP: begin
                        sda_oe_r <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        sda_oe_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe   = sda_oe_r;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Directed bench for i2c_slave_receiver. It models an open-drain bus and bit-bangs write transfers.
// Expected bytes are queued as they are sent and compared whenever rx_valid pulses.
`timescale 1ns/1ps

module tb_i2c_slave_receiver;

    logic clk;
    logic reset;
    logic scl_drv;
    logic sda_drv;

    int   pass_cnt;
    int   total_cnt;
    int   rx_cnt;
    logic [7:0] sb_q[$];

    i2c_slave_receiver_if bus ();

    assign bus.scl_in = scl_drv;
    assign bus.sda_in = sda_drv & ~bus.sda_oe;   // wired-AND open-drain SDA

    i2c_slave_receiver #(
        .SLAVE_ADDR  (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Scoreboard: every rx_valid pulse must match the oldest queued byte.
    always @(negedge clk) begin
        if (!reset && bus.rx_valid === 1'b1) begin
            rx_cnt++;
            check("rx_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) check("rx_data", 32'(bus.rx_data), 32'(sb_q.pop_front()));
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(2); sda_drv = b;
        wait_clk(6); scl_drv = 1'b1;
        wait_clk(8); scl_drv = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic ack_slot(input string tag, input logic exp_oe);
        wait_clk(2); sda_drv = 1'b1;
        wait_clk(6); scl_drv = 1'b1;
        wait_clk(4); check(tag, 32'(bus.sda_oe), 32'(exp_oe));
        wait_clk(4); scl_drv = 1'b0;
    endtask

    task automatic start_cond();
        wait_clk(4); sda_drv = 1'b0;
        wait_clk(8); scl_drv = 1'b0;
    endtask

    task automatic rep_start();
        wait_clk(2); sda_drv = 1'b1;
        wait_clk(6); scl_drv = 1'b1;
        wait_clk(8); sda_drv = 1'b0;
        wait_clk(8); scl_drv = 1'b0;
    endtask

    task automatic stop_cond();
        wait_clk(2); sda_drv = 1'b0;
        wait_clk(6); scl_drv = 1'b1;
        wait_clk(8); sda_drv = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rx_cnt    = 0;
        reset   = 1'b1;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        wait_clk(5);
        check("rst_sda_oe",   32'(bus.sda_oe),   32'd0);
        check("rst_rx_data",  32'(bus.rx_data),  32'h00);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        reset = 1'b0;
        wait_clk(6);

        // 1: matching address, one byte
        start_cond();
        send_byte({7'h50, 1'b0});
        ack_slot("t1_addr_ack", 1'b1);
        check("t1_busy_on", 32'(bus.busy), 32'd1);
        sb_q.push_back(8'hAA);
        send_byte(8'hAA);
        ack_slot("t1_data_ack", 1'b1);
        stop_cond();
        check("t1_busy_off", 32'(bus.busy), 32'd0);
        check("t1_rx_cnt", 32'(rx_cnt), 32'd1);

        // 2: wrong address
        start_cond();
        send_byte({7'h51, 1'b0});
        ack_slot("t2_addr_nack", 1'b0);
        send_byte(8'h3C);
        ack_slot("t2_data_nack", 1'b0);
        check("t2_busy", 32'(bus.busy), 32'd0);
        stop_cond();
        check("t2_rx_cnt", 32'(rx_cnt), 32'd1);
        check("t2_rx_held", 32'(bus.rx_data), 32'hAA);

        // 3: read request is NACKed, rest of transfer ignored
        start_cond();
        send_byte({7'h50, 1'b1});
        ack_slot("t3_addr_nack", 1'b0);
        send_byte({7'h50, 1'b0});
        ack_slot("t3_wait_stop", 1'b0);
        check("t3_busy", 32'(bus.busy), 32'd0);
        stop_cond();
        check("t3_rx_cnt", 32'(rx_cnt), 32'd1);

        // 4: two bytes, three ACKs
        start_cond();
        send_byte({7'h50, 1'b0});
        ack_slot("t4_addr_ack", 1'b1);
        sb_q.push_back(8'h12);
        send_byte(8'h12);
        ack_slot("t4_ack1", 1'b1);
        sb_q.push_back(8'h34);
        send_byte(8'h34);
        ack_slot("t4_ack2", 1'b1);
        stop_cond();
        check("t4_rx_cnt", 32'(rx_cnt), 32'd3);
        check("t4_busy_off", 32'(bus.busy), 32'd0);

        // 5: partial byte then repeated START
        start_cond();
        send_byte({7'h50, 1'b0});
        ack_slot("t5_addr_ack", 1'b1);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        rep_start();
        check("t5_busy_rs", 32'(bus.busy), 32'd0);
        send_byte({7'h50, 1'b0});
        ack_slot("t5_addr_ack2", 1'b1);
        sb_q.push_back(8'h5C);
        send_byte(8'h5C);
        ack_slot("t5_data_ack", 1'b1);
        stop_cond();
        check("t5_rx_cnt", 32'(rx_cnt), 32'd4);

        // 6a: reset while ACKing, then bus ignored until a fresh START
        start_cond();
        send_byte({7'h50, 1'b0});
        wait_clk(2); sda_drv = 1'b1;
        wait_clk(6); scl_drv = 1'b1;
        wait_clk(2);
        check("t6_oe_before", 32'(bus.sda_oe), 32'd1);
        reset = 1'b1;
        wait_clk(1);
        check("t6_oe_reset",   32'(bus.sda_oe), 32'd0);
        check("t6_busy_reset", 32'(bus.busy),   32'd0);
        reset = 1'b0;
        wait_clk(6); scl_drv = 1'b0;
        send_byte({7'h50, 1'b0});
        ack_slot("t6_ignored", 1'b0);
        stop_cond();

        // 6b: one-clk SCL low glitch during the first data bit
        start_cond();
        send_byte({7'h50, 1'b0});
        ack_slot("t6_addr_ack", 1'b1);
`ifdef I2C_SLV_GLITCH_FILTER_EN
        sb_q.push_back(8'hAA);
`else
        sb_q.push_back(8'hD5);   // glitch clocks bit 7 twice, so the byte closes one bit early
`endif
        wait_clk(2); sda_drv = 1'b1;
        wait_clk(6); scl_drv = 1'b1;
        wait_clk(3); scl_drv = 1'b0;
        wait_clk(1); scl_drv = 1'b1;
        wait_clk(4); scl_drv = 1'b0;
        for (int i = 6; i >= 0; i--) send_bit(i[0] ? 1'b1 : 1'b0);
`ifdef I2C_SLV_GLITCH_FILTER_EN
        ack_slot("t6_glitch_ack", 1'b1);
`else
        ack_slot("t6_glitch_ack", 1'b0);
`endif
        stop_cond();
        check("t6_rx_cnt", 32'(rx_cnt), 32'd5);

        wait_clk(20);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
